// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: double-buffered digits, PWM brightness, dead time,
// leading-zero suppression. Define SEG_SCAN_BLINK_EN to add per-digit blinking.
module seg_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 500,
  parameter int BRIGHT_W    = 4
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    lz_en,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ACTIVE = SCAN_DIV - DEAD_CYCLES;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h40;  4'h1: font = 7'h79;  4'h2: font = 7'h24;  4'h3: font = 7'h30;
      4'h4: font = 7'h19;  4'h5: font = 7'h12;  4'h6: font = 7'h02;  4'h7: font = 7'h78;
      4'h8: font = 7'h00;  4'h9: font = 7'h10;  4'hA: font = 7'h08;  4'hB: font = 7'h03;
      4'hC: font = 7'h46;  4'hD: font = 7'h21;  4'hE: font = 7'h06;  default: font = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_data, disp_data;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic [BRIGHT_W-1:0]     bright_r;
  logic                    lz_r;
  logic                    slot_end, frame_end;
  logic [31:0]             on_time;
  logic                    in_window, lit, blink_off;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_supp, cur_blink, lead;
  logic [NUM_DIGITS-1:0]   dig_sel;

  assign slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow is copied to the display only on a frame boundary so a frame never mixes data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      bright_r    <= '1;
      lz_r        <= 1'b0;
      pending     <= 1'b0;
    end else begin
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      if (frame_end) begin
        if (pending) begin
          disp_data <= shadow_data;
          disp_dp   <= shadow_dp;
        end
        bright_r <= brightness;
        lz_r     <= lz_en;
      end
      if (load)
        pending <= 1'b1;
      else if (frame_end)
        pending <= 1'b0;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [NUM_DIGITS-1:0] shadow_blink, disp_blink;
  logic [BF_W-1:0]       frame_cnt;
  logic                  blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_blink <= '0;
      disp_blink   <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
    end else begin
      if (load)
        shadow_blink <= blink_mask;
      if (frame_end) begin
        if (pending)
          disp_blink <= shadow_blink;
        if (frame_cnt == BF_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
`endif

  // lead stays high while every digit scanned so far (from the left) is a bare zero.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_supp  = 1'b0;
    cur_blink = 1'b0;
    dig_sel   = '0;
    lead      = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lead = lead && (disp_data[4*(NUM_DIGITS-1-k) +: 4] == 4'h0) && !disp_dp[NUM_DIGITS-1-k];
      if (idx == IDX_W'(k)) begin
        cur_nib  = disp_data[4*(NUM_DIGITS-1-k) +: 4];
        cur_dp   = disp_dp[NUM_DIGITS-1-k];
        cur_supp = lz_r && lead && (k != NUM_DIGITS - 1);
`ifdef SEG_SCAN_BLINK_EN
        cur_blink = disp_blink[NUM_DIGITS-1-k];
`endif
        dig_sel[NUM_DIGITS-1-k] = 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  assign blink_off = blink_phase && cur_blink;
`else
  assign blink_off = cur_blink;
`endif

  assign on_time   = (32'(ACTIVE) * (32'(bright_r) + 32'd1)) >> BRIGHT_W;
  assign in_window = (32'(cnt) >= 32'(DEAD_CYCLES)) && (32'(cnt) < 32'(DEAD_CYCLES) + on_time);
  assign lit       = in_window && !cur_supp && !blink_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg         <= 8'hFF;
      dig         <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= lit ? {~cur_dp, font(cur_nib)} : 8'hFF;
      dig         <= lit ? ~dig_sel : '1;
      frame_start <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: scoreboard of expected per-cycle outputs.
// Blink scenario runs only when SEG_SCAN_BLINK_EN is defined.
module tb_seg_scan_display;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int DC = 2;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   data_in = '0;
  logic [3:0]    dp_in = '0;
  logic          load = 1'b0;
  logic [3:0]    brightness = 4'hF;
  logic          lz_en = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0]    blink_mask = '0;
`endif
  logic [7:0]    seg;
  logic [3:0]    dig;
  logic          frame_start;
  logic          pending;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];
  logic [6:0]  font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BRIGHT_W(BW)
`ifdef SEG_SCAN_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .load(load),
    .brightness(brightness), .lz_en(lz_en),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg), .dig(dig), .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  // One frame of expected {seg, dig, frame_start}; blank_idx bit k blanks scan position k.
  function automatic void push_frame(input logic [15:0] data, input logic [3:0] dp,
                                     input logic [3:0] bright, input logic lz,
                                     input logic [3:0] blank_idx);
    int on_time, first;
    logic shown;
    logic [3:0] nib;
    logic [7:0] seg_e;
    logic [3:0] dig_e;
    on_time = ((SD - DC) * (int'(bright) + 1)) >> BW;
    first = 3;
    for (int p = 0; p < 3; p++) begin
      if (data[4*(3-p) +: 4] != 4'h0 || dp[3-p]) begin
        first = p;
        break;
      end
    end
    for (int k = 0; k < ND; k++) begin
      for (int c = 0; c < SD; c++) begin
        nib   = data[4*(3-k) +: 4];
        shown = (c >= DC) && (c < DC + on_time) && !(lz && k < first) && !blank_idx[k];
        seg_e = shown ? {~dp[3-k], font_tab[nib]} : 8'hFF;
        dig_e = shown ? ~(4'b1000 >> k) : 4'hF;
        exp_q.push_back({seg_e, dig_e, (k == 0 && c == 0)});
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    data_in = '0;
    dp_in = '0;
    brightness = 4'hF;
    lz_en = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
    blink_mask = '0;
`endif
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_pulse(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
    data_in = d;
    dp_in = p;
`ifdef SEG_SCAN_BLINK_EN
    blink_mask = m;
`else
    if (m != 4'h0) $display("[TB] note: blink mask ignored in this build");
`endif
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns at index 0 of a frame, then samples every negedge for n frames.
  task automatic check_frames(input int n);
    bit ok;
    logic [12:0] e;
    sync_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL frame_sync: frame_start=%b after 200 cycles, expected 1", frame_start);
      exp_q.delete();
      return;
    end
    for (int i = 0; i < 64 * n; i++) begin
      if (i > 0) @(negedge clk);
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_empty at cycle %0d: got nothing to compare, expected entry", i);
        return;
      end
      e = exp_q.pop_front();
      checks++;
      if ({seg, dig, frame_start} !== e) begin
        errors++;
        $display("[TB] FAIL frame_out f=%0d slot=%0d cyc=%0d: got seg=%h dig=%b fs=%b, expected seg=%h dig=%b fs=%b",
                 i / 64, (i % 64) / 16, i % 16, seg, dig, frame_start, e[12:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic check_pending(input string name, input logic expv);
    checks++;
    if (pending !== expv) begin
      errors++;
      $display("[TB] FAIL %s: pending=%b, expected %b", name, pending, expv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({seg, dig, frame_start, pending} !== {8'hFF, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: seg=%h dig=%b fs=%b pend=%b, expected FF 1111 0 0",
               seg, dig, frame_start, pending);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    push_frame(16'h0000, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h1A3F, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h1A3F, 4'h0, 4'hF, 1'b0, 4'h0);
    fork
      check_frames(3);
      begin
        sync_frame(ok);
        repeat (5) @(negedge clk);
        load_pulse(16'h1A3F, 4'h0, 4'h0);
      end
    join
  endtask

  task automatic test_brightness();
    bit ok;
    do_reset();
    push_frame(16'h0000, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h1A3F, 4'h0, 4'h7, 1'b0, 4'h0);
    push_frame(16'h1A3F, 4'h0, 4'h7, 1'b0, 4'h0);
    fork
      check_frames(3);
      begin
        sync_frame(ok);
        repeat (10) @(negedge clk);
        brightness = 4'h7;
        load_pulse(16'h1A3F, 4'h0, 4'h0);
      end
    join
  endtask

  task automatic test_lz();
    bit ok;
    do_reset();
    lz_en = 1'b1;
    push_frame(16'h0000, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h0042, 4'h0, 4'hF, 1'b1, 4'h0);
    push_frame(16'h0000, 4'h0, 4'hF, 1'b1, 4'h0);
    push_frame(16'h0005, 4'b0100, 4'hF, 1'b1, 4'h0);
    fork
      check_frames(4);
      begin
        sync_frame(ok);
        repeat (5) @(negedge clk);
        load_pulse(16'h0042, 4'h0, 4'h0);
        repeat (63) @(negedge clk);
        load_pulse(16'h0000, 4'h0, 4'h0);
        repeat (63) @(negedge clk);
        load_pulse(16'h0005, 4'b0100, 4'h0);
      end
    join
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    push_frame(16'h0000, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h1111, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h2222, 4'h0, 4'hF, 1'b0, 4'h0);
    fork
      check_frames(3);
      begin
        sync_frame(ok);
        check_pending("pending_idle", 1'b0);
        repeat (20) @(negedge clk);
        load_pulse(16'h1111, 4'h0, 4'h0);
        check_pending("pending_after_load", 1'b1);
        repeat (41) @(negedge clk);
        load_pulse(16'h2222, 4'h0, 4'h0);
        check_pending("pending_boundary_load", 1'b1);
        repeat (63) @(negedge clk);
        check_pending("pending_held_frame1", 1'b1);
        @(negedge clk);
        check_pending("pending_cleared", 1'b0);
      end
    join
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    sync_frame(ok);
    repeat (37) @(negedge clk);
    checks++;
    if ({seg, dig} !== {8'hC0, 4'b1101}) begin
      errors++;
      $display("[TB] FAIL digit2_lit: seg=%h dig=%b, expected C0 1101", seg, dig);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({seg, dig, frame_start} !== {8'hFF, 4'hF, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset_blank: seg=%h dig=%b fs=%b, expected FF 1111 0",
               seg, dig, frame_start);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_frame_start: fs=%b, expected 1", frame_start);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({seg, dig} !== {8'hC0, 4'b0111}) begin
      errors++;
      $display("[TB] FAIL restart_idx0: seg=%h dig=%b, expected C0 0111", seg, dig);
    end
  endtask

`ifdef SEG_SCAN_BLINK_EN
  task automatic test_blink();
    bit ok;
    do_reset();
    push_frame(16'h0000, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h1A3F, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h1A3F, 4'h0, 4'hF, 1'b0, 4'b1000);
    push_frame(16'h1A3F, 4'h0, 4'hF, 1'b0, 4'b1000);
    push_frame(16'h1A3F, 4'h0, 4'hF, 1'b0, 4'h0);
    push_frame(16'h1A3F, 4'h0, 4'hF, 1'b0, 4'h0);
    fork
      check_frames(6);
      begin
        sync_frame(ok);
        repeat (5) @(negedge clk);
        load_pulse(16'h1A3F, 4'h0, 4'b0001);
      end
    join
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_brightness();
    test_lz();
    test_back_to_back();
    test_reset_mid();
`ifdef SEG_SCAN_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
